// File: rtl/control_sequencer.sv
// Microcode-style control sequencer for a small accumulator machine: a fixed
// six T-state fetch/execute ring with an opcode decode in T4-T6 and a sticky HALT.
module control_sequencer (
   input  logic       MainClock,
   input  logic       ResetN,
   input  logic       Run,
   input  logic [3:0] Opcode,
   input  logic       CarryFlag,
   output logic       PcEnable,
   output logic       PcInc,
   output logic       PcLoad,
   output logic       MarLatch,
   output logic       RamEnable,
   output logic       IrLatch,
   output logic       IrEnable,
   output logic       ClearA,
   output logic       LatchA,
   output logic       EnableA,
   output logic       LatchB,
   output logic       AluEnable,
   output logic       AluSub,
   output logic       LatchOut,
   output logic [2:0] TState,
   output logic       Halted,
   output logic [7:0] InstrCount
);

   typedef enum logic [2:0] {
      Idle = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      T4   = 3'd4,
      T5   = 3'd5,
      T6   = 3'd6,
      Halt = 3'd7
   } stateT;

   localparam logic [3:0] OpLda = 4'b0000;
   localparam logic [3:0] OpAdd = 4'b0001;
   localparam logic [3:0] OpSub = 4'b0010;
   localparam logic [3:0] OpLdi = 4'b0101;
   localparam logic [3:0] OpJmp = 4'b0110;
   localparam logic [3:0] OpJc  = 4'b0111;
   localparam logic [3:0] OpOut = 4'b1110;
   localparam logic [3:0] OpHlt = 4'b1111;

   stateT state;
   stateT nextState;
   logic  instrDone;

   // Run is a level start request with no acknowledge; it is only looked at in Idle.
   always_ff @(posedge MainClock) begin
      if (!ResetN) begin
         state      <= Idle;
         InstrCount <= 8'd0;
      end else begin
         state <= nextState;
         if (instrDone) begin
            InstrCount <= InstrCount + 8'd1;
         end
      end
   end

   always_comb begin
      nextState = state;
      PcEnable  = 1'b0;
      PcInc     = 1'b0;
      PcLoad    = 1'b0;
      MarLatch  = 1'b0;
      RamEnable = 1'b0;
      IrLatch   = 1'b0;
      IrEnable  = 1'b0;
      ClearA    = 1'b0;
      LatchA    = 1'b0;
      EnableA   = 1'b0;
      LatchB    = 1'b0;
      AluEnable = 1'b0;
      AluSub    = 1'b0;
      LatchOut  = 1'b0;
      case (state)
         Idle: begin
            ClearA = 1'b1;
            if (Run) nextState = T1;
         end
         T1: begin
            PcEnable  = 1'b1;
            MarLatch  = 1'b1;
            nextState = T2;
         end
         T2: begin
            PcInc     = 1'b1;
            nextState = T3;
         end
         T3: begin
            RamEnable = 1'b1;
            IrLatch   = 1'b1;
            nextState = T4;
         end
         T4: begin
            nextState = T5;
            case (Opcode)
               OpLda, OpAdd, OpSub: begin
                  IrEnable = 1'b1;
                  MarLatch = 1'b1;
               end
               OpLdi: begin
                  IrEnable = 1'b1;
                  LatchA   = 1'b1;
               end
               OpJmp: begin
                  IrEnable = 1'b1;
                  PcLoad   = 1'b1;
               end
               OpJc: begin
                  IrEnable = 1'b1;
                  PcLoad   = CarryFlag;
               end
               OpOut: begin
                  EnableA  = 1'b1;
                  LatchOut = 1'b1;
               end
               OpHlt:   nextState = Halt;
               default: ;
            endcase
         end
         T5: begin
            nextState = T6;
            case (Opcode)
               OpLda: begin
                  RamEnable = 1'b1;
                  LatchA    = 1'b1;
               end
               OpAdd, OpSub: begin
                  RamEnable = 1'b1;
                  LatchB    = 1'b1;
               end
               default: ;
            endcase
         end
         T6: begin
            nextState = T1;
            if (Opcode == OpAdd || Opcode == OpSub) begin
               AluEnable = 1'b1;
               LatchA    = 1'b1;
               AluSub    = (Opcode == OpSub);
            end
         end
         Halt: ;
      endcase
   end

   // An instruction retires when the ring closes or when HLT parks the machine.
   assign instrDone = ((state == T6) && (nextState == T1)) ||
                      ((state == T4) && (nextState == Halt));

   assign TState = state;
   assign Halted = (state == Halt);

endmodule
